exception_control: RTL
======================

Name: exception_control

Overview:
- Trap controller for the 5-stage pipeline; it is the producer of the Interrupt/Exception strobes and the saved return address that the register file consumes to write $26 ($k0).
- Watches the ID stage for illegal instructions and the timer IRQ, and redirects fetch to the kernel handler.
- Flushes IF/ID and tracks kernel mode until the handler returns via jr $26.
- Sits beside the hazard unit; its outputs feed the PC mux, the IF/ID flush, and the register file's Interrupt, Exception and PC_plus_4 inputs.

Parameters:
- ILLOP_VEC, 32'h80000004, handler address for illegal-instruction exception.
- INT_VEC, 32'h80000008, handler address for interrupt.
- SYNC_STAGES, 2, flop depth of irq synchronizer (>=2).

Ports:
- clk  in  1  system clock
- reset  in  1  async active-high reset
- irq  in  1  level request from timer, asynchronous to clk
- id_valid  in  1  ID stage holds a real (non-bubble) instruction
- id_pc  in  32  PC of instruction in ID; bit 31 = supervisor bit
- id_pc_plus_4  in  32  id_pc + 4
- id_illegal  in  1  decoder flags undefined opcode/funct in ID
- id_eret  in  1  decoder flags jr $26 in ID
- pipe_stall  in  1  load-use stall; ID instruction not advancing this cycle
- interrupt  out  1  one-cycle strobe to register file
- exception  out  1  one-cycle strobe to register file
- flush  out  1  squash IF and ID this cycle
- pc_redirect  out  1  PC mux selects redirect_pc
- redirect_pc  out  32  handler vector
- epc  out  32  return address; wired to register-file PC_plus_4
- cause  out  2  01 interrupt, 10 exception, 00 none
- kernel_mode  out  1  handler executing
- irq_pending  out  1  latched unserviced interrupt

Behaviour:
- Reset (async): state USER; all outputs 0; epc 0; cause 00; sync flops and pending cleared. Same behaviour if reset is asserted mid-trap.
- IRQ path:
  - irq passes through SYNC_STAGES flops, then a rising-edge detector.
  - An edge sets irq_pending. Pending clears at the posedge that enters TRAP for an interrupt.
  - If a new edge arrives in that same cycle, pending stays 1 (set wins).
- Trap condition (USER only), evaluated combinationally as take = id_valid & !pipe_stall.
  - Exception: take & id_illegal. Has priority over interrupt in the same cycle.
  - Interrupt: take & irq_pending & !id_pc[31] & !id_illegal.
- States:
  - USER: kernel_mode 0, strobes 0. On a trap condition, at the next posedge:
    - go to TRAP;
    - epc <= id_pc_plus_4 for an exception, id_pc for an interrupt (the interrupted instruction is re-executed);
    - cause is updated.
  - TRAP: exactly one cycle.
    - interrupt or exception = 1 per cause.
    - flush = 1, pc_redirect = 1.
    - redirect_pc = ILLOP_VEC or INT_VEC.
    - Next state KERNEL unconditionally; stall and irq are ignored.
  - KERNEL: kernel_mode 1.
    - irq edges still set pending but are not taken.
    - id_illegal is ignored (no nesting).
    - id_valid & !pipe_stall & id_eret -> USER at the next posedge.
    - epc and cause hold.
- After return to USER, a still-pending irq traps on the first eligible instruction, earliest the cycle after entering USER.
- Latency: a trap condition in cycle N produces the strobe, flush and redirect in cycle N+1. The register file captures epc into $26 at the end of N+1.
- While pipe_stall = 1, no trap is taken; the condition re-evaluates each cycle.
- The interrupt and exception strobes are never high together, and never high outside TRAP.

Decomposition:
- Package cpu_exc_pkg: state encoding (USER/TRAP/KERNEL), cause codes, default vector constants.
- Sub-module irq_sync_edge: parameterised synchronizer plus rising-edge detect, output one-cycle pulse.

Test Plan:
- Reset then id_valid=1, id_illegal=1, id_pc=32'h00000100 -> next cycle exception=1, flush=1, redirect_pc=32'h80000004, epc=32'h00000104, cause=10; following cycle kernel_mode=1, strobes 0.
- irq pulse with user instructions streaming at id_pc=32'h00000200 -> after SYNC_STAGES+1 cycles irq_pending=1; trap cycle shows interrupt=1, redirect_pc=32'h80000008, epc=32'h00000200 (the id_pc held when the trap was taken), irq_pending=0.
- id_illegal and irq_pending in the same cycle -> exception=1, interrupt=0, irq_pending stays 1; after id_eret, interrupt is taken on the next user instruction.
- irq edge while kernel_mode=1 -> no strobe, irq_pending=1 held; id_eret with pipe_stall=1 -> remains KERNEL; stall released -> USER, then interrupt trap.
- Trap condition with pipe_stall=1 for 3 cycles -> no strobe during stall; strobe the cycle after stall drops.
- Reset asserted during TRAP -> all outputs 0 immediately; cause=00, epc=0, kernel_mode=0.

Source files
------------

// File: rtl/cpu_exc_pkg.sv
// Shared definitions for the trap controller: state encoding, cause codes and
// the default handler vectors.
package cpu_exc_pkg;

    typedef enum logic [1:0] {
        ST_USER   = 2'b00,
        ST_TRAP   = 2'b01,
        ST_KERNEL = 2'b10
    } exc_state_t;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_INT  = 2'b01;
    localparam logic [1:0] CAUSE_EXC  = 2'b10;

    localparam logic [31:0] DEF_ILLOP_VEC = 32'h8000_0004;
    localparam logic [31:0] DEF_INT_VEC   = 32'h8000_0008;

    // Selects the handler entry point for a given trap cause.
    function automatic logic [31:0] trap_vector(input logic [1:0]  cause_code,
                                                input logic [31:0] illop_vec,
                                                input logic [31:0] int_vec);
        logic [31:0] vec;
        vec = illop_vec;
        if (cause_code == CAUSE_INT) begin
            vec = int_vec;
        end
        return vec;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Brings an asynchronous level request into the clk domain and emits a
// one-cycle pulse on each synchronized rising edge.
module irq_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic pulse
);

    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], async_in};
            prev <= sync[STAGES-1];
        end
    end

    assign pulse = sync[STAGES-1] & ~prev;

endmodule

// File: rtl/exception_control.sv
// Trap controller: takes illegal-instruction exceptions and timer interrupts
// from ID, redirects fetch to the handler and tracks kernel mode until eret.
module exception_control
    import cpu_exc_pkg::*;
#(
    parameter logic [31:0] ILLOP_VEC   = DEF_ILLOP_VEC,
    parameter logic [31:0] INT_VEC     = DEF_INT_VEC,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        irq,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_pc_plus_4,
    input  logic        id_illegal,
    input  logic        id_eret,
    input  logic        pipe_stall,
    output logic        interrupt,
    output logic        exception,
    output logic        flush,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc,
    output logic [31:0] epc,
    output logic [1:0]  cause,
    output logic        kernel_mode,
    output logic        irq_pending
);

    exc_state_t state;
    logic       irq_edge;
    logic       take;
    logic       take_exc;
    logic       take_int;

    irq_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_irq_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (irq),
        .pulse    (irq_edge)
    );

    // Traps are only considered for a real instruction that advances this
    // cycle; an illegal opcode outranks a pending interrupt.
    always_comb begin
        take     = id_valid & ~pipe_stall;
        take_exc = 1'b0;
        take_int = 1'b0;
        if (state == ST_USER) begin
            take_exc = take & id_illegal;
            take_int = take & irq_pending & ~id_pc[31] & ~id_illegal;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_USER;
            interrupt   <= 1'b0;
            exception   <= 1'b0;
            flush       <= 1'b0;
            pc_redirect <= 1'b0;
            redirect_pc <= 32'h0;
            epc         <= 32'h0;
            cause       <= CAUSE_NONE;
            kernel_mode <= 1'b0;
            irq_pending <= 1'b0;
        end else begin
            // A new edge in the same cycle as the interrupt is taken keeps it pending.
            irq_pending <= irq_edge | (irq_pending & ~take_int);

            case (state)
                ST_USER: begin
                    if (take_exc) begin
                        state       <= ST_TRAP;
                        exception   <= 1'b1;
                        flush       <= 1'b1;
                        pc_redirect <= 1'b1;
                        redirect_pc <= trap_vector(CAUSE_EXC, ILLOP_VEC, INT_VEC);
                        epc         <= id_pc_plus_4;
                        cause       <= CAUSE_EXC;
                    end else if (take_int) begin
                        // The interrupted instruction re-executes after eret.
                        state       <= ST_TRAP;
                        interrupt   <= 1'b1;
                        flush       <= 1'b1;
                        pc_redirect <= 1'b1;
                        redirect_pc <= trap_vector(CAUSE_INT, ILLOP_VEC, INT_VEC);
                        epc         <= id_pc;
                        cause       <= CAUSE_INT;
                    end
                end
                ST_TRAP: begin
                    state       <= ST_KERNEL;
                    interrupt   <= 1'b0;
                    exception   <= 1'b0;
                    flush       <= 1'b0;
                    pc_redirect <= 1'b0;
                    redirect_pc <= 32'h0;
                    kernel_mode <= 1'b1;
                end
                ST_KERNEL: begin
                    if (take & id_eret) begin
                        state       <= ST_USER;
                        kernel_mode <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_USER;
                    interrupt   <= 1'b0;
                    exception   <= 1'b0;
                    flush       <= 1'b0;
                    pc_redirect <= 1'b0;
                    redirect_pc <= 32'h0;
                    kernel_mode <= 1'b0;
                end
            endcase
        end
    end

    a_strobe_exclusive : assert property (@(posedge clk) disable iff (reset)
        !(interrupt && exception));

    a_strobe_in_trap : assert property (@(posedge clk) disable iff (reset)
        (interrupt || exception) |-> (state == ST_TRAP));

endmodule
